// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel video capture: synchronizes PCLK/VSYNC/HREF/D into clk, pairs bytes
// into RGB565 pixels with a linear frame-buffer address, and flags malformed lines/frames.
module ov7670_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              single_shot,
  input  logic              err_clr,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic              err_sticky,
  output logic [7:0]        frame_count,
  output logic [1:0]        state_dbg
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_END     = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_END     = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t state, state_next;

  logic       pclk_s1, pclk_s2, pclk_s3;
  logic       vs_s1, vs_s2, vs_s3;
  logic       hr_s1, hr_s2, hr_s3;
  logic [7:0] d_s1, d_s2;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] line_base;
  logic              phase;
  logic [7:0]        hi;
  logic              shot_hold;

  logic pclk_rise, vs_rise, vs_fall, href_fall;
  logic in_cap, byte_ev, pair_ev, in_range, emit, line_end, go_capture, err_set;
  logic [YW-1:0] y_after;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_s1 <= 1'b0; pclk_s2 <= 1'b0; pclk_s3 <= 1'b0;
      vs_s1   <= 1'b0; vs_s2   <= 1'b0; vs_s3   <= 1'b0;
      hr_s1   <= 1'b0; hr_s2   <= 1'b0; hr_s3   <= 1'b0;
      d_s1    <= 8'd0; d_s2    <= 8'd0;
    end else begin
      pclk_s1 <= cam_pclk;  pclk_s2 <= pclk_s1; pclk_s3 <= pclk_s2;
      vs_s1   <= cam_vsync; vs_s2   <= vs_s1;   vs_s3   <= vs_s2;
      hr_s1   <= cam_href;  hr_s2   <= hr_s1;   hr_s3   <= hr_s2;
      d_s1    <= cam_data;  d_s2    <= d_s1;
    end
  end

  always_comb begin
    pclk_rise  = pclk_s2 & ~pclk_s3;
    vs_rise    = vs_s2 & ~vs_s3;
    vs_fall    = ~vs_s2 & vs_s3;
    href_fall  = ~hr_s2 & hr_s3;
    in_cap     = (state == CAPTURE);
    byte_ev    = in_cap & pclk_rise & hr_s2;
    pair_ev    = byte_ev & phase;
    in_range   = (x < X_END) & (y < Y_END);
    emit       = pair_ev & in_range;
    line_end   = in_cap & href_fall;
    go_capture = (state == WAIT_FRAME) & enable & vs_fall;
    // A line end coinciding with VSYNC rise is counted before the frame-length check.
    y_after    = (line_end && (y < Y_END)) ? y + 1'b1 : y;
    err_set    = (pair_ev & ~in_range)
               | (line_end & (phase | (x != X_END)))
               | (in_cap & enable & vs_rise & (y_after != Y_END));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // After a single-shot frame, capture stays parked until enable is dropped and reasserted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (enable && !shot_hold) state_next = WAIT_FRAME;
      WAIT_FRAME: if (!enable) state_next = IDLE;
                  else if (vs_fall) state_next = CAPTURE;
      CAPTURE:    if (!enable) state_next = IDLE;
                  else if (vs_rise) state_next = DONE;
      DONE:       state_next = (single_shot || !enable) ? IDLE : WAIT_FRAME;
      default:    state_next = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // pix_valid is a one-cycle strobe with no backpressure: the consumer must accept
  // pix_data/pix_addr in the cycle pix_valid is high; both hold their value otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_valid   <= 1'b0;
      pix_data    <= 16'd0;
      pix_addr    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_sticky  <= 1'b0;
      frame_count <= 8'd0;
      x           <= '0;
      y           <= '0;
      line_base   <= '0;
      phase       <= 1'b0;
      hi          <= 8'd0;
      shot_hold   <= 1'b0;
    end else begin
      pix_valid   <= emit;
      frame_start <= go_capture;
      frame_done  <= (state == DONE);
      if (state == DONE) frame_count <= frame_count + 8'd1;

      if (!enable) shot_hold <= 1'b0;
      else if (state == DONE && single_shot) shot_hold <= 1'b1;

      if (err_set)      err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;

      if (emit) begin
        pix_data <= {hi, d_s2};
        pix_addr <= line_base + ADDR_W'(x);
      end

      if (go_capture) begin
        x         <= '0;
        y         <= '0;
        line_base <= '0;
        phase     <= 1'b0;
        hi        <= 8'd0;
      end else if (line_end) begin
        x     <= '0;
        phase <= 1'b0;
        if (y < Y_END) begin
          y         <= y + 1'b1;
          line_base <= line_base + LINE_STEP;
        end
      end else if (byte_ev) begin
        if (!phase) begin
          hi    <= d_s2;
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (in_range) x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ov7670_pixel_capture.md
Name: ov7670_pixel_capture

Overview:
- Downstream consumer of the OV7670 once the SCCB register load has finished.
- Samples the camera's parallel video bus (PCLK, VSYNC, HREF, D[7:0]) in the system clock domain.
- Pairs the bytes into RGB565 pixels and presents each pixel with a linear frame-buffer write address.
- Generates frame framing pulses and a sticky error flag for malformed lines and frames.

Parameters:
- H_ACTIVE, 640, pixels per line (two bytes per pixel)
- V_ACTIVE, 480, lines per frame
- ADDR_W, 19, width of pix_addr; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- clk  in  1  system clock; frequency must be >= 4x cam_pclk
- reset  in  1  asynchronous, active-low reset
- enable  in  1  level; arms capture (driven by config-complete logic)
- single_shot  in  1  1 = capture one frame then return to IDLE
- err_clr  in  1  one-cycle pulse; clears err_sticky
- cam_pclk  in  1  camera pixel clock (asynchronous to clk)
- cam_vsync  in  1  camera VSYNC; high during vertical blanking
- cam_href  in  1  camera HREF; high during active bytes
- cam_data  in  8  camera data bus
- pix_valid  out  1  one-cycle strobe; pix_data and pix_addr are valid
- pix_data  out  16  RGB565 pixel, {first byte, second byte}
- pix_addr  out  ADDR_W  linear address of the pixel, y*H_ACTIVE + x
- frame_start  out  1  one-cycle pulse at the start of a captured frame
- frame_done  out  1  one-cycle pulse at the end of a captured frame
- busy  out  1  high in WAIT_FRAME, CAPTURE and DONE
- err_sticky  out  1  set on any framing error; held until err_clr
- frame_count  out  8  count of completed frames; wraps 255->0

Behaviour:
- Reset (reset=0, asynchronous assert): state IDLE; all outputs, counters and synchronizer stages 0.
- Synchronization:
  - cam_pclk, cam_vsync, cam_href and cam_data each pass through an identical 2-FF chain.
  - A third pclk register provides edge detect; pclk_rise = s2 & ~s3.
  - VSYNC edges are detected the same way.
  - Sampled href/data are always taken from the s2 stage.
- States and transitions:
  - IDLE: enable=1 -> WAIT_FRAME.
  - WAIT_FRAME: VSYNC falling edge -> CAPTURE. On entry: pulse frame_start for one cycle; clear x, y, addr and byte phase.
  - CAPTURE, on pclk_rise with href=1:
    - phase 0: latch the high byte; phase -> 1.
    - phase 1: form {hi, data}; phase -> 0. If x < H_ACTIVE and y < V_ACTIVE, emit the pixel; otherwise drop it and set err.
  - Emitting a pixel: pix_valid is high for exactly one clk, in the cycle after the detecting cycle. pix_addr increments after each emitted pixel; x increments.
  - CAPTURE, on href falling edge (synchronized):
    - Set err if phase=1 (odd byte count) or x != H_ACTIVE.
    - Then x=0, phase=0, y+1 (saturating at V_ACTIVE).
  - CAPTURE, on VSYNC rising edge -> DONE. Set err if y != V_ACTIVE.
  - DONE (one cycle): pulse frame_done; increment frame_count. Next state is IDLE if single_shot=1 or enable=0, else WAIT_FRAME.
- enable=0 in WAIT_FRAME or CAPTURE aborts to IDLE next cycle:
  - no frame_done, frame_count unchanged;
  - a pixel already registered still completes its pix_valid cycle.
- pix_addr is never >= H_ACTIVE*V_ACTIVE when pix_valid=1.
- pix_data and pix_addr hold their last values when pix_valid=0.
- err_clr asserted in the same cycle as a new error event: err_sticky = 1 (set wins).
- Simultaneous href falling and VSYNC rising: process the line end first, then transition to DONE.
- Total latency from a camera PCLK rising edge to pix_valid: 3-4 clk.

Test Plan:
- Use H_ACTIVE=4, V_ACTIVE=2, clk = 8x pclk.
- Reset: assert reset mid-stimulus -> all outputs 0 immediately. After release with enable=0 -> busy=0, no pix_valid.
- Nominal frame, enable=1: VSYNC fall, 2 lines of 8 bytes 0x10..0x1F -> 8 pix_valid pulses. pix_data 0x1011, 0x1213, ..., 0x1E1F; pix_addr 0..7. One frame_start, then frame_done after VSYNC rise; frame_count=1, err_sticky=0.
- Odd byte count: line 0 carries 7 bytes -> 3 pixels emitted on line 0, err_sticky=1. Frame still completes with frame_done. err_clr -> err_sticky=0.
- Overlong/extra lines: line 0 carries 10 bytes and a 3rd line is sent -> 4 pixels kept per line, excess dropped. pix_addr max 7, err_sticky=1.
- single_shot=1: two back-to-back frames -> exactly one frame_done, busy=0 after DONE. Second frame produces no pix_valid.
- Abort: drop enable after 3 pixels -> busy=0 within 2 clk, no frame_done, frame_count unchanged. Re-enable -> next frame captured from pix_addr 0.
